// File: rtl/project_ugpe_xdrop.sv
// ---------------------------------------------------------------------------
// project_ugpe_xdrop
//   Ungapped seed-extension engine for the BLASTN accelerator. Accepts one
//   seed hit together with a packed query window and database window, then
//   walks right from the seed and afterwards left of it, one base pair per
//   clock. Each direction stops on an X-drop test or at the window edge.
//   The result carries the combined score, extension length and start
//   coordinates. The four store addresses are passed through unchanged.
//
// Ports
//   clk          clock
//   reset        asynchronous active-low reset
//   istream_*    val/rdy input message:
//                {addr_score, addr_len, addr_d_start, addr_q_start,
//                 d_hit, q_hit, database, query}   (query at LSB)
//   ostream_*    val/rdy result message:
//                {addr_score, addr_len, addr_d_start, addr_q_start,
//                 d_start, q_start, len, score}     (score at LSB, signed)
//
// Sequences are packed two bits per base, with base k at bits [2k+1:2k].
// ---------------------------------------------------------------------------

// One extension step: scores one base pair and evaluates the X-drop test.
module project_ugpe_xdrop_step #(
    parameter int MATCH    = 1,
    parameter int MISMATCH = 1,
    parameter int XDROP    = 3
) (
    input  logic [1:0]         q_base,
    input  logic [1:0]         d_base,
    input  logic signed [31:0] cur,
    input  logic signed [31:0] best,
    output logic signed [31:0] cur_nx,
    output logic signed [31:0] best_nx,
    output logic               better,
    output logic               drop
);
    localparam logic signed [31:0] MATCH_S    = 32'(MATCH);
    localparam logic signed [31:0] MISMATCH_S = 32'(MISMATCH);
    localparam logic signed [31:0] XDROP_S    = 32'(XDROP);

    always_comb begin
        cur_nx  = (q_base == d_base) ? cur + MATCH_S : cur - MISMATCH_S;
        // A strict improvement is required, so on a tie the shorter extent wins.
        better  = cur_nx > best;
        best_nx = better ? cur_nx : best;
        drop    = (best_nx - cur_nx) > XDROP_S;
    end
endmodule

module project_ugpe_xdrop #(
    parameter int SEQ_LEN  = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = 1,
    parameter int XDROP    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     istream_val,
    output logic                     istream_rdy,
    input  logic [4*SEQ_LEN+191:0]   istream_msg,
    output logic                     ostream_val,
    input  logic                     ostream_rdy,
    output logic [255:0]             ostream_msg
);
    localparam int             IW       = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(SEQ_LEN - 1);
    localparam logic [31:0]    SEQ_LEN_W = 32'(SEQ_LEN);

    typedef struct packed {
        logic [31:0]            addr_score;
        logic [31:0]            addr_len;
        logic [31:0]            addr_d_start;
        logic [31:0]            addr_q_start;
        logic [31:0]            d_hit;
        logic [31:0]            q_hit;
        logic [2*SEQ_LEN-1:0]   database;
        logic [2*SEQ_LEN-1:0]   query;
    } req_t;

    typedef struct packed {
        logic [31:0] addr_score;
        logic [31:0] addr_len;
        logic [31:0] addr_d_start;
        logic [31:0] addr_q_start;
        logic [31:0] d_start;
        logic [31:0] q_start;
        logic [31:0] len;
        logic [31:0] score;
    } resp_t;

    typedef enum logic [1:0] {IDLE, EXT_R, EXT_L, DONE} state_t;

    state_t             state, state_nx;
    req_t               in_req, req;
    resp_t              res;

    logic signed [31:0] cur, best, rbest;
    logic signed [31:0] cur_nx, best_nx;
    logic [31:0]        cnt;            // bases examined in the current direction
    logic [31:0]        rlen, llen;
    logic [IW-1:0]      qi, dj;         // current query / database base index
    logic [1:0]         q_base, d_base;
    logic               better, drop, at_edge, term;
    logic               accept, in_oor, left_skip;

    assign in_req = istream_msg;

    // Gated with reset so the engine only advertises ready once released.
    assign istream_rdy = (state == IDLE) && reset;
    assign accept      = istream_val && istream_rdy;

    assign in_oor    = (in_req.q_hit >= SEQ_LEN_W) || (in_req.d_hit >= SEQ_LEN_W);
    assign left_skip = (req.q_hit == 32'd0) || (req.d_hit == 32'd0);

    assign q_base = req.query[{qi, 1'b0} +: 2];
    assign d_base = req.database[{dj, 1'b0} +: 2];

    project_ugpe_xdrop_step #(
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .XDROP    (XDROP)
    ) u_step (
        .q_base  (q_base),
        .d_base  (d_base),
        .cur     (cur),
        .best    (best),
        .cur_nx  (cur_nx),
        .best_nx (best_nx),
        .better  (better),
        .drop    (drop)
    );

    // The walk ends after the base that sits on the window boundary.
    always_comb begin
        if (state == EXT_L) at_edge = (qi == '0) || (dj == '0);
        else                at_edge = (qi == LAST_IDX) || (dj == LAST_IDX);
        term = drop || at_edge;
    end

    // Result assembly. When the left pass is skipped or the seed is out of
    // range, best is still zero, so score reduces to the right-hand best.
    always_comb begin
        res.addr_score   = req.addr_score;
        res.addr_len     = req.addr_len;
        res.addr_d_start = req.addr_d_start;
        res.addr_q_start = req.addr_q_start;
        res.d_start      = req.d_hit - llen;
        res.q_start      = req.q_hit - llen;
        res.len          = rlen + llen;
        res.score        = rbest + best;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)                     state_nx = in_oor ? DONE : EXT_R;
            EXT_R:   if (term)                       state_nx = left_skip ? DONE : EXT_L;
            EXT_L:   if (term)                       state_nx = DONE;
            DONE:    if (ostream_val && ostream_rdy) state_nx = IDLE;
            default:                                 state_nx = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req         <= '0;
            cur         <= '0;
            best        <= '0;
            rbest       <= '0;
            cnt         <= '0;
            rlen        <= '0;
            llen        <= '0;
            qi          <= '0;
            dj          <= '0;
            ostream_val <= 1'b0;
            ostream_msg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req   <= in_req;
                        cur   <= '0;
                        best  <= '0;
                        rbest <= '0;
                        cnt   <= '0;
                        rlen  <= '0;
                        llen  <= '0;
                        qi    <= in_req.q_hit[IW-1:0];
                        dj    <= in_req.d_hit[IW-1:0];
                    end
                end
                EXT_R: begin
                    cur  <= cur_nx;
                    best <= best_nx;
                    cnt  <= cnt + 32'd1;
                    qi   <= qi + IW'(1);
                    dj   <= dj + IW'(1);
                    if (better) rlen <= cnt + 32'd1;
                    if (term) begin
                        // Bank the right-hand best and restart just left of the seed.
                        rbest <= best_nx;
                        cur   <= '0;
                        best  <= '0;
                        cnt   <= '0;
                        qi    <= req.q_hit[IW-1:0] - IW'(1);
                        dj    <= req.d_hit[IW-1:0] - IW'(1);
                    end
                end
                EXT_L: begin
                    // best is kept on exit and serves as the left-hand best.
                    cur  <= cur_nx;
                    best <= best_nx;
                    cnt  <= cnt + 32'd1;
                    qi   <= qi - IW'(1);
                    dj   <= dj - IW'(1);
                    if (better) llen <= cnt + 32'd1;
                end
                DONE: begin
                    // The first DONE cycle registers the result. The message
                    // then stays frozen until the consumer takes it.
                    if (!ostream_val) begin
                        ostream_val <= 1'b1;
                        ostream_msg <= res;
                    end else if (ostream_rdy) begin
                        ostream_val <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_project_ugpe_xdrop.sv
module tb_project_ugpe_xdrop;
    localparam int S        = 16;
    localparam int MATCH    = 1;
    localparam int MISMATCH = 1;
    localparam int XDROP    = 3;
    localparam int MW       = 4*S + 192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          istream_val = 1'b0;
    logic          istream_rdy;
    logic [MW-1:0] istream_msg = '0;
    logic          ostream_val;
    logic          ostream_rdy = 1'b0;
    logic [255:0]  ostream_msg;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    project_ugpe_xdrop #(.SEQ_LEN(S), .MATCH(MATCH), .MISMATCH(MISMATCH), .XDROP(XDROP)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [MW-1:0] mk_msg(input logic [2*S-1:0] q, d,
                                             input logic [31:0] qh, dh, aqs, ads, al, asc);
        return {asc, al, ads, aqs, dh, qh, d, q};
    endfunction

    function automatic logic [255:0] mk_resp(input logic [31:0] asc, al, ads, aqs, ds, qs, len, score);
        return {asc, al, ads, aqs, ds, qs, len, score};
    endfunction

    function automatic int base_at(input logic [2*S-1:0] s, input int k);
        logic [2*S-1:0] t;
        t = s >> (2*k);
        return int'(t[1:0]);
    endfunction

    // Reference: walk each direction over plain integer indices, tracking
    // the running and best score; the cycle count is one plus every base examined.
    function automatic void model(input logic [MW-1:0] m, output logic [255:0] r, output int lat);
        logic [2*S-1:0] q, d;
        logic [31:0]    qh, dh;
        int tot, steps, rl, ll, cur, best, n, bl, qi, dj, stp;
        q = m[2*S-1:0];
        d = m[4*S-1:2*S];
        qh = m[4*S+31:4*S];
        dh = m[4*S+63:4*S+32];
        tot = 0; steps = 0; rl = 0; ll = 0;
        if (qh >= S || dh >= S) begin
            r = {m[MW-1 -: 128], dh, qh, 64'd0};
            lat = 1;
            return;
        end
        for (int dir = 0; dir < 2; dir++) begin
            stp = (dir == 0) ? 1 : -1;
            qi = int'(qh) + ((dir == 0) ? 0 : -1);
            dj = int'(dh) + ((dir == 0) ? 0 : -1);
            cur = 0; best = 0; n = 0; bl = 0;
            while (qi >= 0 && qi < S && dj >= 0 && dj < S) begin
                n++;
                cur += (base_at(q, qi) == base_at(d, dj)) ? MATCH : -MISMATCH;
                if (cur > best) begin best = cur; bl = n; end
                if (best - cur > XDROP) break;
                qi += stp;
                dj += stp;
            end
            tot += best;
            steps += n;
            if (dir == 0) rl = bl; else ll = bl;
        end
        r = {m[MW-1 -: 128], dh - 32'(ll), qh - 32'(ll), 32'(rl + ll), 32'(tot)};
        lat = 1 + steps;
    endfunction

    // Drive one message, then count posedges until ostream_val is seen.
    // While waiting, optionally keep offering a different message to prove
    // it is ignored; busy_bad counts cycles where the engine looked ready.
    task automatic run_job(input logic [MW-1:0] m, input bit noise, output logic [255:0] resp,
                           output int lat, output logic acc_rdy, output int busy_bad);
        @(negedge clk);
        istream_msg = m;
        istream_val = 1'b1;
        acc_rdy = istream_rdy;
        @(posedge clk);
        @(negedge clk);
        istream_val = noise;
        if (noise) istream_msg = ~m;
        lat = 0;
        busy_bad = 0;
        while (ostream_val !== 1'b1 && lat < 100) begin
            if (istream_rdy !== 1'b0) busy_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        istream_val = 1'b0;
        resp = ostream_msg;
    endtask

    task automatic consume(output logic val_after, output logic rdy_after);
        ostream_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ostream_rdy = 1'b0;
        val_after = ostream_val;
        rdy_after = istream_rdy;
    endtask

    localparam logic [2*S-1:0] T1_SEQ = 32'h01234567;

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vecs++;
        if (ostream_val !== 1'b0 || ostream_msg !== 256'd0) begin
            miss++;
            $display("FAIL reset_out got val=%b msg=%h want val=0 msg=0", ostream_val, ostream_msg);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vecs++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
            miss++;
            $display("FAIL reset_release got rdy=%b val=%b want rdy=1 val=0", istream_rdy, ostream_val);
        end
    endtask

    task automatic test_identical();
        logic [255:0] resp, exp;
        int lat, bb;
        logic acc, va, ra;
        exp = mk_resp(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 16, 16);
        run_job(mk_msg(T1_SEQ, T1_SEQ, 5, 5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111),
                1'b0, resp, lat, acc, bb);
        vecs++; if (acc !== 1'b1 || bb != 0) begin miss++; $display("FAIL t1_handshake got rdy=%b busy=%0d want 1/0", acc, bb); end
        vecs++; if (resp !== exp) begin miss++; $display("FAIL t1_resp got %h want %h", resp, exp); end
        vecs++; if (lat != 17) begin miss++; $display("FAIL t1_latency got %0d want 17", lat); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL t1_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    task automatic test_xdrop();
        logic [255:0] resp, exp;
        int lat, bb;
        logic acc, va, ra;
        exp = mk_resp(32'hA4, 32'hA3, 32'hA2, 32'hA1, 0, 0, 8, 8);
        run_job(mk_msg(32'h00000000, 32'h55550000, 4, 4, 32'hA1, 32'hA2, 32'hA3, 32'hA4),
                1'b1, resp, lat, acc, bb);
        vecs++; if (acc !== 1'b1 || bb != 0) begin miss++; $display("FAIL t2_handshake got rdy=%b busy=%0d want 1/0", acc, bb); end
        vecs++; if (resp !== exp) begin miss++; $display("FAIL t2_resp got %h want %h", resp, exp); end
        vecs++; if (lat != 13) begin miss++; $display("FAIL t2_latency got %0d want 13", lat); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL t2_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    task automatic test_out_of_range();
        logic [255:0] resp, exp;
        int lat, bb;
        logic acc, va, ra;
        exp = mk_resp(32'hB4, 32'hB3, 32'hB2, 32'hB1, 3, 16, 0, 0);
        run_job(mk_msg(T1_SEQ, T1_SEQ, 16, 3, 32'hB1, 32'hB2, 32'hB3, 32'hB4), 1'b0, resp, lat, acc, bb);
        vecs++; if (resp !== exp) begin miss++; $display("FAIL t3_resp got %h want %h", resp, exp); end
        vecs++; if (lat != 1) begin miss++; $display("FAIL t3_latency got %0d want 1", lat); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL t3_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    task automatic test_left_edge();
        logic [255:0] resp, exp;
        int lat, bb;
        logic acc, va, ra;
        exp = mk_resp(32'hC4, 32'hC3, 32'hC2, 32'hC1, 0, 0, 16, 16);
        run_job(mk_msg(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hC1, 32'hC2, 32'hC3, 32'hC4), 1'b0, resp, lat, acc, bb);
        vecs++; if (resp !== exp) begin miss++; $display("FAIL t4_resp got %h want %h", resp, exp); end
        vecs++; if (lat != 17) begin miss++; $display("FAIL t4_latency got %0d want 17", lat); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL t4_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    // Seed mismatches and every base mismatches: score 0, length 0, starts at the seed.
    task automatic test_all_mismatch();
        logic [255:0] resp, exp;
        int lat, bb;
        logic acc, va, ra;
        exp = mk_resp(32'hD4, 32'hD3, 32'hD2, 32'hD1, 3, 3, 0, 0);
        run_job(mk_msg(32'h00000000, 32'hFFFFFFFF, 3, 3, 32'hD1, 32'hD2, 32'hD3, 32'hD4), 1'b0, resp, lat, acc, bb);
        vecs++; if (resp !== exp) begin miss++; $display("FAIL mismatch_resp got %h want %h", resp, exp); end
        vecs++; if (lat != 8) begin miss++; $display("FAIL mismatch_latency got %0d want 8", lat); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL mismatch_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    task automatic test_backpressure();
        logic [255:0] resp, exp;
        int lat, bb, bad;
        logic acc, va, ra;
        exp = mk_resp(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 16, 16);
        run_job(mk_msg(T1_SEQ, T1_SEQ, 5, 5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111),
                1'b0, resp, lat, acc, bb);
        vecs++; if (resp !== exp || lat != 17) begin miss++; $display("FAIL t5_first got %h lat %0d want %h lat 17", resp, lat, exp); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ostream_val !== 1'b1 || ostream_msg !== exp || istream_rdy !== 1'b0) bad++;
        end
        vecs++; if (bad != 0) begin miss++; $display("FAIL t5_hold got %0d bad cycles want 0", bad); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL t5_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    task automatic test_reset_mid_job();
        logic [255:0] resp, exp;
        int lat, bb;
        logic acc, va, ra;
        logic [MW-1:0] m;
        m = mk_msg(T1_SEQ, T1_SEQ, 5, 5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111);
        exp = mk_resp(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 16, 16);
        // Reset while extending right.
        @(negedge clk);
        istream_msg = m;
        istream_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        vecs++; if (ostream_val !== 1'b0 || ostream_msg !== 256'd0) begin miss++; $display("FAIL t6_ext_reset got val=%b msg=%h want 0/0", ostream_val, ostream_msg); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vecs++; if (istream_rdy !== 1'b1) begin miss++; $display("FAIL t6_idle got rdy=%b want 1", istream_rdy); end
        run_job(m, 1'b0, resp, lat, acc, bb);
        vecs++; if (resp !== exp || lat != 17) begin miss++; $display("FAIL t6_rerun got %h lat %0d want %h lat 17", resp, lat, exp); end
        // Reset while a result is being held.
        #3 reset = 1'b0;
        #1;
        vecs++; if (ostream_val !== 1'b0 || ostream_msg !== 256'd0) begin miss++; $display("FAIL t6_done_reset got val=%b msg=%h want 0/0", ostream_val, ostream_msg); end
        @(negedge clk);
        reset = 1'b1;
        run_job(m, 1'b0, resp, lat, acc, bb);
        vecs++; if (resp !== exp || lat != 17) begin miss++; $display("FAIL t6_rerun2 got %h lat %0d want %h lat 17", resp, lat, exp); end
        consume(va, ra);
        vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL t6_release got val=%b rdy=%b want 0/1", va, ra); end
    endtask

    task automatic test_random();
        logic [255:0] resp, exp;
        int lat, bb, elat;
        logic acc, va, ra;
        logic [31:0] q, d, qh, dh;
        logic [MW-1:0] m;
        for (int n = 0; n < 40; n++) begin
            q = $urandom;
            d = ($urandom_range(0, 4) == 0) ? $urandom : (q ^ ($urandom & $urandom & $urandom));
            qh = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(16, 40)) : 32'($urandom_range(0, 15));
            dh = ($urandom_range(0, 2) == 0) ? qh : 32'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) dh = $urandom | 32'h8000_0000;
            m = mk_msg(q, d, qh, dh, $urandom, $urandom, $urandom, $urandom);
            model(m, exp, elat);
            run_job(m, 1'b1, resp, lat, acc, bb);
            vecs++; if (acc !== 1'b1 || bb != 0) begin miss++; $display("FAIL rnd%0d_handshake got rdy=%b busy=%0d want 1/0", n, acc, bb); end
            vecs++; if (resp !== exp) begin miss++; $display("FAIL rnd%0d_resp got %h want %h", n, resp, exp); end
            vecs++; if (lat != elat) begin miss++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, elat); end
            consume(va, ra);
            vecs++; if (va !== 1'b0 || ra !== 1'b1) begin miss++; $display("FAIL rnd%0d_release got val=%b rdy=%b want 0/1", n, va, ra); end
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_xdrop();
        test_out_of_range();
        test_left_edge();
        test_all_mismatch();
        test_backpressure();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
